// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard unit.
package fwd_pkg;

  // EX operand mux select, one per source operand.
  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_MEM_WB = 2'b01,
    FWD_EX_MEM = 2'b10
  } fwd_sel_t;

  // Load-use stall sequencer states.
  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the ID stage and the forwarding / hazard unit.
interface fwd_hazard_unit_if #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_ADDR_W = 5
) ();

  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs;
  logic [NUM_SRC-1:0]            id_rs_used;
  logic [REG_ADDR_W-1:0]         id_ex_rd;
  logic                          id_ex_reg_write;
  logic                          id_ex_mem_read;
  logic [REG_ADDR_W-1:0]         ex_mem_rd;
  logic                          ex_mem_reg_write;
  logic                          ex_stall;
  logic                          flush;
  logic [2*NUM_SRC-1:0]          fwd_sel;
  logic                          stall;
  logic                          bubble;

  // Pipeline side: presents the ID sources and downstream destinations.
  modport master (
    output id_rs, id_rs_used, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
    output ex_mem_rd, ex_mem_reg_write, ex_stall, flush,
    input  fwd_sel, stall, bubble
  );

  // Hazard unit side.
  modport slave (
    input  id_rs, id_rs_used, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
    input  ex_mem_rd, ex_mem_reg_write, ex_stall, flush,
    output fwd_sel, stall, bubble
  );

endinterface

// File: rtl/fwd_src_cmp.sv
// Per-source comparator: forwarding select and load-use contribution for one operand.
module fwd_src_cmp
  import fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  rs_used,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_reg_write,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  ex_mem_reg_write,
  output fwd_sel_t              next_sel,
  output logic                  lu_hit
);

  logic match_ex;
  logic match_mem;

  // Younger producer (ID/EX) wins; x0 never matches.
  always_comb begin
    match_ex  = rs_used && (rs != '0) && id_ex_reg_write && (rs == id_ex_rd);
    match_mem = rs_used && (rs != '0) && ex_mem_reg_write && (rs == ex_mem_rd);
    lu_hit    = match_ex && id_ex_mem_read;
    if (match_ex && !id_ex_mem_read) begin
      next_sel = FWD_EX_MEM;
    end else if (match_mem) begin
      next_sel = FWD_MEM_WB;
    end else begin
      // Current MEM/WB writer is covered by the write-through regfile.
      next_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Registered forwarding selects and load-use stall sequencer beside the ID stage.
module fwd_hazard_unit #(
  parameter int unsigned NUM_SRC           = 2,
  parameter int unsigned REG_ADDR_W        = 5,
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_unit_if.slave bus
);
  import fwd_pkg::*;

  localparam int unsigned CntW = $clog2(LOAD_STALL_CYCLES) + 1;

  fwd_sel_t             next_sel [NUM_SRC];
  logic [NUM_SRC-1:0]   src_lu_hit;
  logic                 lu_hit;
  logic                 stall_int;
  logic [2*NUM_SRC-1:0] sel_d, sel_q;
  hz_state_t            state_d, state_q;
  logic [CntW-1:0]      cnt_d, cnt_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_cmp #(
      .REG_ADDR_W (REG_ADDR_W)
    ) u_cmp (
      .rs               (bus.id_rs[i*REG_ADDR_W +: REG_ADDR_W]),
      .rs_used          (bus.id_rs_used[i]),
      .id_ex_rd         (bus.id_ex_rd),
      .id_ex_reg_write  (bus.id_ex_reg_write),
      .id_ex_mem_read   (bus.id_ex_mem_read),
      .ex_mem_rd        (bus.ex_mem_rd),
      .ex_mem_reg_write (bus.ex_mem_reg_write),
      .next_sel         (next_sel[i]),
      .lu_hit           (src_lu_hit[i])
    );
  end

  assign lu_hit = |src_lu_hit;

  // Stall sequencer: next state, counter and combinational stall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_int = 1'b0;
    unique case (state_q)
      RUN: begin
        stall_int = lu_hit;
        // Single-bubble case needs no extra state: ID/EX holds the bubble next cycle.
        if (lu_hit && (LOAD_STALL_CYCLES > 1)) begin
          state_d = LU_STALL;
          cnt_d   = CntW'(LOAD_STALL_CYCLES - 1);
        end
      end
      LU_STALL: begin
        stall_int = 1'b1;
        if (cnt_q <= CntW'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    // Flush squashes ID and aborts any pending stall.
    if (bus.flush) begin
      stall_int = 1'b0;
      state_d   = RUN;
      cnt_d     = '0;
    end
  end

  // Next operand selects; a squashed or bubbled slot reads the regfile.
  always_comb begin
    sel_d = '0;
    if (!bus.flush && !stall_int) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        sel_d[2*i +: 2] = next_sel[i];
      end
    end
  end

  // State and select registers; a frozen EX holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else if (!bus.ex_stall) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.fwd_sel = sel_q;
  assign bus.stall   = stall_int;
  assign bus.bubble  = stall_int;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: A = 2 sources / 1 bubble, B = 3 sources / 3 bubbles.
module tb_fwd_hazard_unit;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [3:0] sb_a [$];
  logic [5:0] sb_b [$];
  logic [3:0] exp_a;
  logic [5:0] exp_b;

  typedef struct {
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic [4:0] ex_rd;
    logic       ex_we;
    logic [4:0] mem_rd;
    logic       mem_we;
    logic [3:0] sel;
  } vec_t;

  vec_t tbl [5] = '{
    '{5'd7, 5'd0,  2'b11, 5'd7, 1'b1, 5'd7,  1'b1, 4'b0010},
    '{5'd7, 5'd3,  2'b11, 5'd3, 1'b1, 5'd7,  1'b1, 4'b1001},
    '{5'd0, 5'd0,  2'b11, 5'd0, 1'b1, 5'd0,  1'b1, 4'b0000},
    '{5'd9, 5'd9,  2'b00, 5'd9, 1'b1, 5'd9,  1'b1, 4'b0000},
    '{5'd9, 5'd12, 2'b11, 5'd9, 1'b0, 5'd12, 1'b1, 4'b0100}
  };

  fwd_hazard_unit_if #(.NUM_SRC(2), .REG_ADDR_W(5)) ifa ();
  fwd_hazard_unit_if #(.NUM_SRC(3), .REG_ADDR_W(5)) ifb ();

  fwd_hazard_unit #(
    .NUM_SRC           (2),
    .REG_ADDR_W        (5),
    .LOAD_STALL_CYCLES (1)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  fwd_hazard_unit #(
    .NUM_SRC           (3),
    .REG_ADDR_W        (5),
    .LOAD_STALL_CYCLES (3)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_a(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                         input logic [4:0] ex_rd, input logic ex_we, input logic ex_ld,
                         input logic [4:0] mem_rd, input logic mem_we,
                         input logic exs, input logic fl);
    ifa.id_rs            = {rs1, rs0};
    ifa.id_rs_used       = used;
    ifa.id_ex_rd         = ex_rd;
    ifa.id_ex_reg_write  = ex_we;
    ifa.id_ex_mem_read   = ex_ld;
    ifa.ex_mem_rd        = mem_rd;
    ifa.ex_mem_reg_write = mem_we;
    ifa.ex_stall         = exs;
    ifa.flush            = fl;
  endtask

  task automatic drive_b(input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] used, input logic [4:0] ex_rd, input logic ex_we,
                         input logic ex_ld, input logic [4:0] mem_rd, input logic mem_we,
                         input logic exs, input logic fl);
    ifb.id_rs            = {rs2, rs1, rs0};
    ifb.id_rs_used       = used;
    ifb.id_ex_rd         = ex_rd;
    ifb.id_ex_reg_write  = ex_we;
    ifb.id_ex_mem_read   = ex_ld;
    ifb.ex_mem_rd        = mem_rd;
    ifb.ex_mem_reg_write = mem_we;
    ifb.ex_stall         = exs;
    ifb.flush            = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (ifa.fwd_sel !== 4'b0000) begin
      errors++; $display("FAIL reset_sel_a: got %b want 0000", ifa.fwd_sel);
    end
    checks++;
    if (ifb.fwd_sel !== 6'b000000) begin
      errors++; $display("FAIL reset_sel_b: got %b want 000000", ifb.fwd_sel);
    end
    checks++;
    if (ifa.stall !== 1'b0 || ifa.bubble !== 1'b0) begin
      errors++; $display("FAIL reset_stall_a: got %b/%b want 0/0", ifa.stall, ifa.bubble);
    end
    checks++;
    if (ifb.stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall_b: got %b want 0", ifb.stall);
    end
  endtask

  task automatic test_alu_alu();
    drive_a(5'd5, 5'd0, 2'b11, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ifa.stall !== 1'b0) begin
      errors++; $display("FAIL alu_stall: got %b want 0", ifa.stall);
    end
    sb_a.push_back(4'b0010);
    tick();
    exp_a = sb_a.pop_front();
    checks++;
    if (ifa.fwd_sel !== exp_a) begin
      errors++; $display("FAIL alu_sel: got %b want %b", ifa.fwd_sel, exp_a);
    end
  endtask

  task automatic test_double_hazard();
    foreach (tbl[i]) begin
      drive_a(tbl[i].rs0, tbl[i].rs1, tbl[i].used, tbl[i].ex_rd, tbl[i].ex_we, 1'b0,
              tbl[i].mem_rd, tbl[i].mem_we, 1'b0, 1'b0);
      #1;
      checks++;
      if (ifa.stall !== 1'b0) begin
        errors++; $display("FAIL dbl_stall[%0d]: got %b want 0", i, ifa.stall);
      end
      sb_a.push_back(tbl[i].sel);
      tick();
      exp_a = sb_a.pop_front();
      checks++;
      if (ifa.fwd_sel !== exp_a) begin
        errors++; $display("FAIL dbl_sel[%0d]: got %b want %b", i, ifa.fwd_sel, exp_a);
      end
    end
  endtask

  task automatic test_load_use_a();
    logic [2:0] st_exp [3] = '{1'b1, 1'b0, 1'b0};
    // Load x3 in ID/EX, dependent in ID; then bubble/load move down; then idle.
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive_a(5'd3, 5'd0, 2'b01, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      else if (c == 1) drive_a(5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
      else drive_a(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (ifa.stall !== st_exp[c][0] || ifa.bubble !== st_exp[c][0]) begin
        errors++; $display("FAIL lu_a_stall[%0d]: got %b/%b want %b", c, ifa.stall, ifa.bubble,
                           st_exp[c][0]);
      end
      sb_a.push_back((c == 1) ? 4'b0001 : 4'b0000);
      tick();
      exp_a = sb_a.pop_front();
      checks++;
      if (ifa.fwd_sel !== exp_a) begin
        errors++; $display("FAIL lu_a_sel[%0d]: got %b want %b", c, ifa.fwd_sel, exp_a);
      end
    end
  endtask

  task automatic test_load_use_b();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive_b(5'd1, 5'd2, 5'd4, 3'b111, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      else if (c == 1) drive_b(5'd1, 5'd2, 5'd4, 3'b111, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0,
                               1'b0);
      else drive_b(5'd1, 5'd2, 5'd4, 3'b111, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (ifb.stall !== (c < 3)) begin
        errors++; $display("FAIL lu_b_stall[%0d]: got %b want %b", c, ifb.stall, (c < 3));
      end
      sb_b.push_back(6'b000000);
      tick();
      exp_b = sb_b.pop_front();
      checks++;
      if (ifb.fwd_sel !== exp_b) begin
        errors++; $display("FAIL lu_b_sel[%0d]: got %b want %b", c, ifb.fwd_sel, exp_b);
      end
    end
  endtask

  task automatic test_flush();
    // Flush in RUN while a load-use hit is present.
    drive_a(5'd3, 5'd0, 2'b01, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (ifa.stall !== 1'b0) begin
      errors++; $display("FAIL flush_a_stall: got %b want 0", ifa.stall);
    end
    drive_a(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    // Flush in LU_STALL on B.
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive_b(5'd1, 5'd2, 5'd4, 3'b111, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      else drive_b(5'd1, 5'd2, 5'd4, 3'b111, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, (c == 1));
      #1;
      checks++;
      if (ifb.stall !== (c == 0)) begin
        errors++; $display("FAIL flush_b_stall[%0d]: got %b want %b", c, ifb.stall, (c == 0));
      end
      sb_b.push_back((c == 2) ? 6'b010000 : 6'b000000);
      tick();
      exp_b = sb_b.pop_front();
      checks++;
      if (ifb.fwd_sel !== exp_b) begin
        errors++; $display("FAIL flush_b_sel[%0d]: got %b want %b", c, ifb.fwd_sel, exp_b);
      end
    end
    drive_b(5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ex_stall();
    logic [3:0] sel_exp [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0100};
    logic       st_exp  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: drive_a(5'd5, 5'd0, 2'b11, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        1: drive_a(5'd1, 5'd12, 2'b11, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
        2: drive_a(5'd3, 5'd0, 2'b01, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        3: drive_a(5'd3, 5'd0, 2'b01, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        default: drive_a(5'd1, 5'd12, 2'b11, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
      endcase
      #1;
      checks++;
      if (ifa.stall !== st_exp[c]) begin
        errors++; $display("FAIL exs_a_stall[%0d]: got %b want %b", c, ifa.stall, st_exp[c]);
      end
      sb_a.push_back(sel_exp[c]);
      tick();
      exp_a = sb_a.pop_front();
      checks++;
      if (ifa.fwd_sel !== exp_a) begin
        errors++; $display("FAIL exs_a_sel[%0d]: got %b want %b", c, ifa.fwd_sel, exp_a);
      end
    end
    drive_a(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    // Counter must hold across a two-cycle freeze on B.
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive_b(5'd1, 5'd2, 5'd4, 3'b111, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      else if (c == 5) drive_b(5'd1, 5'd2, 5'd4, 3'b111, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0,
                               1'b0);
      else drive_b(5'd1, 5'd2, 5'd4, 3'b111, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, (c < 3), 1'b0);
      #1;
      checks++;
      if (ifb.stall !== (c < 5)) begin
        errors++; $display("FAIL exs_b_stall[%0d]: got %b want %b", c, ifb.stall, (c < 5));
      end
      sb_b.push_back((c == 5) ? 6'b000100 : 6'b000000);
      tick();
      exp_b = sb_b.pop_front();
      checks++;
      if (ifb.fwd_sel !== exp_b) begin
        errors++; $display("FAIL exs_b_sel[%0d]: got %b want %b", c, ifb.fwd_sel, exp_b);
      end
    end
    drive_b(5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    drive_a(5'd5, 5'd0, 2'b11, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive_b(5'd1, 5'd2, 5'd4, 3'b111, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive_b(5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    checks++;
    if (ifb.stall !== 1'b1 || ifa.fwd_sel !== 4'b0010) begin
      errors++; $display("FAIL arst_pre: got stall_b=%b sel_a=%b want 1/0010", ifb.stall,
                         ifa.fwd_sel);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ifb.stall !== 1'b0 || ifb.bubble !== 1'b0) begin
      errors++; $display("FAIL arst_stall: got %b/%b want 0/0", ifb.stall, ifb.bubble);
    end
    checks++;
    if (ifa.fwd_sel !== 4'b0000 || ifb.fwd_sel !== 6'b000000) begin
      errors++; $display("FAIL arst_sel: got %b/%b want 0/0", ifa.fwd_sel, ifb.fwd_sel);
    end
    drive_a(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    drive_a(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive_b(5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #12;
    test_reset();
    rst_n = 1'b1;
    test_alu_alu();
    test_double_hazard();
    test_load_use_a();
    test_load_use_b();
    test_flush();
    test_ex_stall();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion want completion");
    $fatal(1);
  end

endmodule
